// File: rtl/demux_pkg.sv
// Shared constants and state type for the 1-to-16 sequential demultiplexer.
package demux_pkg;

    localparam int LANES = 16;
    localparam int SEL_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

endpackage

// File: rtl/dec_4_16.sv
// Combinational 4-to-16 one-hot decoder producing the lane-write enables.
module dec_4_16
    import demux_pkg::*;
(
    input  logic [SEL_W-1:0] addr,
    output logic [LANES-1:0] onehot
);

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign onehot[gi] = (addr == SEL_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/demux_1_16_seq.sv
// 1-to-16 demultiplexer with an addressed-write mode and a sequential scan-frame mode.
// Optional frame parity output is enabled by defining DEMUX_PARITY_EN.
module demux_1_16_seq
    import demux_pkg::*;
#(
    parameter int CLEAR_ON_FRAME = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic [SEL_W-1:0] sel,
    input  logic             mode,
    input  logic             in_valid,
    input  logic             abort,
    output logic [LANES-1:0] out,
    output logic [LANES-1:0] out_stb,
    output logic             frame_done,
    output logic             busy
`ifdef DEMUX_PARITY_EN
    ,
    output logic             frame_par
`endif
);

    state_t           state;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] dec_addr;
    logic [LANES-1:0] lane_en;
    logic [LANES-1:0] wr_data;
    logic [LANES-1:0] start_data;
    logic             last_lane;

    // ptr is always 0 in IDLE, so it doubles as the lane-0 address for a frame start.
    assign dec_addr = (state == SCAN || mode) ? ptr : sel;

    dec_4_16 u_dec (
        .addr   (dec_addr),
        .onehot (lane_en)
    );

    assign wr_data    = (out & ~lane_en) | (lane_en & {LANES{din}});
    assign start_data = (CLEAR_ON_FRAME != 0) ? (lane_en & {LANES{din}}) : wr_data;
    assign last_lane  = (ptr == SEL_W'(LANES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            out        <= '0;
            out_stb    <= '0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            out_stb    <= '0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        out_stb <= lane_en;
                        if (!mode) begin
                            out <= wr_data;
                        end else begin
                            out   <= start_data;
                            ptr   <= SEL_W'(1);
                            state <= SCAN;
                            busy  <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    // Abort takes priority over a coincident beat.
                    if (abort) begin
                        state <= IDLE;
                        ptr   <= '0;
                        busy  <= 1'b0;
                    end else if (in_valid) begin
                        out     <= wr_data;
                        out_stb <= lane_en;
                        if (last_lane) begin
                            frame_done <= 1'b1;
                            state      <= IDLE;
                            ptr        <= '0;
                            busy       <= 1'b0;
                        end else begin
                            ptr <= ptr + SEL_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    ptr   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef DEMUX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_par <= 1'b0;
        end else if (state == SCAN && !abort && in_valid && last_lane) begin
            frame_par <= ^wr_data;
        end
    end
`endif

endmodule

// File: tb/tb_demux_1_16_seq.sv
// Scoreboard bench for demux_1_16_seq: two instances (lane clear on/off) share one stimulus stream.
module tb_demux_1_16_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        din;
    logic [3:0]  sel;
    logic        mode;
    logic        in_valid;
    logic        abort;
    logic [15:0] out_a, out_c, stb_a, stb_c;
    logic        fd_a, fd_c, busy_a, busy_c;
`ifdef DEMUX_PARITY_EN
    logic        par_a, par_c;
`endif

    always #5 clk = ~clk;

    demux_1_16_seq #(.CLEAR_ON_FRAME(0)) dut (
        .clk(clk), .rst(rst), .din(din), .sel(sel), .mode(mode),
        .in_valid(in_valid), .abort(abort), .out(out_a), .out_stb(stb_a),
        .frame_done(fd_a), .busy(busy_a)
`ifdef DEMUX_PARITY_EN
        , .frame_par(par_a)
`endif
    );

    demux_1_16_seq #(.CLEAR_ON_FRAME(1)) dut_c (
        .clk(clk), .rst(rst), .din(din), .sel(sel), .mode(mode),
        .in_valid(in_valid), .abort(abort), .out(out_c), .out_stb(stb_c),
        .frame_done(fd_c), .busy(busy_c)
`ifdef DEMUX_PARITY_EN
        , .frame_par(par_c)
`endif
    );

    typedef struct packed {
        logic [15:0] out_a;
        logic [15:0] out_c;
        logic [15:0] stb;
        logic        fd;
        logic        busy;
        logic        par_a;
        logic        par_c;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state
    logic        m_scan;
    logic [3:0]  m_ptr;
    logic [15:0] m_out_a, m_out_c;
    logic        m_par_a, m_par_c;

    task automatic model_reset();
        m_scan = 1'b0; m_ptr = 4'd0; m_out_a = 16'h0; m_out_c = 16'h0;
        m_par_a = 1'b0; m_par_c = 1'b0;
    endtask

    // Drive one cycle of inputs, push the model's prediction, return 1 ns after the edge.
    task automatic step(input logic v, input logic d, input logic [3:0] s,
                        input logic m, input logic a);
        exp_t x;
        @(negedge clk);
        in_valid = v; din = d; sel = s; mode = m; abort = a;
        x = '0;
        if (!m_scan) begin
            if (v && !m) begin
                m_out_a[s] = d; m_out_c[s] = d; x.stb = 16'h1 << s;
            end else if (v && m) begin
                m_out_a[0] = d; m_out_c = {15'h0, d}; x.stb = 16'h0001;
                m_ptr = 4'd1; m_scan = 1'b1;
            end
        end else if (a) begin
            m_scan = 1'b0; m_ptr = 4'd0;
        end else if (v) begin
            m_out_a[m_ptr] = d; m_out_c[m_ptr] = d; x.stb = 16'h1 << m_ptr;
            if (m_ptr == 4'd15) begin
                x.fd = 1'b1; m_scan = 1'b0; m_ptr = 4'd0;
                m_par_a = ^m_out_a; m_par_c = ^m_out_c;
            end else begin
                m_ptr = m_ptr + 4'd1;
            end
        end
        x.out_a = m_out_a; x.out_c = m_out_c; x.busy = m_scan;
        x.par_a = m_par_a; x.par_c = m_par_c;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; din = 0; sel = 0; mode = 0; in_valid = 0; abort = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (out_a !== 16'h0 || out_c !== 16'h0 || stb_a !== 16'h0 || stb_c !== 16'h0 ||
            fd_a !== 1'b0 || fd_c !== 1'b0 || busy_a !== 1'b0 || busy_c !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: out=%h/%h stb=%h/%h fd=%b/%b busy=%b/%b, required all zero",
                     out_a, out_c, stb_a, stb_c, fd_a, fd_c, busy_a, busy_c);
        end else $display("reset: outputs zero");
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One scoreboard pop and comparison per beat, driven from a small table.
    task automatic test_addressed();
        logic [3:0] sels [6] = '{4'd3, 4'd12, 4'd5, 4'd5, 4'd0, 4'd15};
        logic       dins [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic       abts [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            step(1'b1, dins[i], sels[i], 1'b0, abts[i]);
            e = sb.pop_front();
            n_checks++;
            if (out_a !== e.out_a || out_c !== e.out_c || stb_a !== e.stb || stb_c !== e.stb ||
                fd_a !== e.fd || fd_c !== e.fd || busy_a !== e.busy || busy_c !== e.busy) begin
                n_fail++;
                $display("FAIL addressed[%0d]: out=%h/%h stb=%h/%h fd=%b busy=%b, required out=%h/%h stb=%h fd=%b busy=%b",
                         i, out_a, out_c, stb_a, stb_c, fd_a, busy_a, e.out_a, e.out_c, e.stb, e.fd, e.busy);
            end else $display("addressed[%0d]: sel=%0d out=%h stb=%h", i, sels[i], out_a, stb_a);
            if (i == 1) begin
                n_checks++;
                if (out_a !== 16'h1008 || stb_a !== 16'h1000) begin
                    n_fail++;
                    $display("FAIL addr_fixed: out=%h stb=%h, required out=1008 stb=1000", out_a, stb_a);
                end
            end
        end
    endtask

    // Scan a 16-bit pattern LSB first; gap_after bits insert 3 idle cycles after that beat.
    task automatic test_scan(input string name, input logic [15:0] pat,
                             input logic [15:0] gap_after, input int abort_beat);
        for (int b = 0; b < 16; b++) begin
            step(1'b1, pat[b], 4'($urandom_range(15)), (b == 0) ? 1'b1 : 1'($urandom_range(1)),
                 (b == abort_beat) ? 1'b1 : 1'b0);
            e = sb.pop_front();
            n_checks++;
            if (out_a !== e.out_a || out_c !== e.out_c || stb_a !== e.stb || stb_c !== e.stb ||
                fd_a !== e.fd || fd_c !== e.fd || busy_a !== e.busy || busy_c !== e.busy) begin
                n_fail++;
                $display("FAIL %s beat %0d: out=%h/%h stb=%h fd=%b busy=%b, required out=%h/%h stb=%h fd=%b busy=%b",
                         name, b + 1, out_a, out_c, stb_a, fd_a, busy_a, e.out_a, e.out_c, e.stb, e.fd, e.busy);
            end else $display("%s beat %0d: out=%h stb=%h fd=%b busy=%b", name, b + 1, out_a, stb_a, fd_a, busy_a);
            if (b == abort_beat) break;
            if (gap_after[b]) begin
                for (int g = 0; g < 3; g++) begin
                    step(1'b0, 1'b1, 4'($urandom_range(15)), 1'b1, 1'b0);
                    e = sb.pop_front();
                    n_checks++;
                    if (stb_a !== 16'h0 || stb_c !== 16'h0 || out_a !== e.out_a || out_c !== e.out_c ||
                        busy_a !== e.busy || fd_a !== 1'b0) begin
                        n_fail++;
                        $display("FAIL %s gap %0d: stb=%h/%h out=%h busy=%b fd=%b, required stb=0 out=%h busy=%b fd=0",
                                 name, g, stb_a, stb_c, out_a, busy_a, fd_a, e.out_a, e.busy);
                    end
                end
            end
        end
        // Idle cycle after the frame: busy must be low and frame_done gone.
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        e = sb.pop_front();
        n_checks++;
        if (busy_a !== 1'b0 || busy_c !== 1'b0 || fd_a !== 1'b0 || stb_a !== 16'h0 || out_a !== e.out_a || out_c !== e.out_c) begin
            n_fail++;
            $display("FAIL %s after: busy=%b/%b fd=%b stb=%h out=%h/%h, required busy=0 fd=0 stb=0 out=%h/%h",
                     name, busy_a, busy_c, fd_a, stb_a, out_a, out_c, e.out_a, e.out_c);
        end else $display("%s done: out=%h/%h", name, out_a, out_c);
`ifdef DEMUX_PARITY_EN
        n_checks++;
        if (par_a !== e.par_a || par_c !== e.par_c) begin
            n_fail++;
            $display("FAIL %s parity: par=%b/%b, required %b/%b", name, par_a, par_c, e.par_a, e.par_c);
        end
`endif
    endtask

    task automatic test_fixed_results();
        // Independent constants for the headline scenarios.
        test_scan("scan_a5c3", 16'hA5C3, 16'h0000, 99);
        n_checks++;
        if (out_a !== 16'hA5C3 || out_c !== 16'hA5C3) begin
            n_fail++;
            $display("FAIL scan_a5c3_final: out=%h/%h, required a5c3", out_a, out_c);
        end
        test_scan("scan_gaps", 16'h5A3C, 16'h0108, 99);
        test_scan("scan_gaps_a5c3", 16'hA5C3, 16'h0108, 99);
        n_checks++;
        if (out_a !== 16'hA5C3) begin
            n_fail++;
            $display("FAIL scan_gaps_final: out=%h, required a5c3", out_a);
        end
        // Abort on beat 8 with zeros: lanes 0..6 cleared, lane 7 keeps its 1.
        test_scan("scan_abort", 16'h0000, 16'h0000, 7);
        n_checks++;
        if (out_a !== 16'hA580 || busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_final: out=%h busy=%b, required out=a580 busy=0", out_a, busy_a);
        end
    endtask

    task automatic test_reset_mid_frame();
        for (int b = 0; b < 4; b++) begin
            step(1'b1, 1'b1, 4'd9, (b == 0) ? 1'b1 : 1'b0, 1'b0);
            void'(sb.pop_front());
        end
        @(negedge clk);
        in_valid = 1'b1; rst = 1'b1;
        #1;
        n_checks++;
        if (out_a !== 16'h0 || out_c !== 16'h0 || busy_a !== 1'b0 || busy_c !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: out=%h/%h busy=%b/%b, required out=0 busy=0", out_a, out_c, busy_a, busy_c);
        end else $display("reset_mid: cleared");
        @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0;
        model_reset();
        step(1'b1, 1'b1, 4'd15, 1'b0, 1'b0);
        e = sb.pop_front();
        n_checks++;
        if (out_a !== 16'h8000 || out_c !== 16'h8000 || stb_a !== 16'h8000 || busy_a !== 1'b0 || e.out_a !== out_a) begin
            n_fail++;
            $display("FAIL post_reset_write: out=%h/%h stb=%h busy=%b, required out=8000 stb=8000 busy=0",
                     out_a, out_c, stb_a, busy_a);
        end else $display("post_reset_write: out=%h", out_a);
    endtask

    task automatic test_clear_on_frame();
        for (int l = 0; l < 16; l++) begin
            step(1'b1, 1'b1, 4'(l), 1'b0, 1'b0);
            void'(sb.pop_front());
        end
        // Start edge: clearing instance keeps only lane 0, the other keeps FFFF.
        step(1'b1, 1'b1, 4'd7, 1'b1, 1'b0);
        e = sb.pop_front();
        n_checks++;
        if (out_a !== 16'hFFFF || out_c !== 16'h0001 || busy_c !== 1'b1 || out_c !== e.out_c) begin
            n_fail++;
            $display("FAIL clear_start: out=%h/%h busy=%b, required ffff/0001 busy=1", out_a, out_c, busy_c);
        end else $display("clear_start: out=%h/%h", out_a, out_c);
        for (int b = 1; b < 16; b++) begin
            step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
            e = sb.pop_front();
            n_checks++;
            if (out_a !== e.out_a || out_c !== e.out_c || stb_c !== e.stb || fd_c !== e.fd) begin
                n_fail++;
                $display("FAIL clear beat %0d: out=%h/%h stb=%h fd=%b, required %h/%h stb=%h fd=%b",
                         b + 1, out_a, out_c, stb_c, fd_c, e.out_a, e.out_c, e.stb, e.fd);
            end
        end
        n_checks++;
        if (out_a !== 16'h0001 || out_c !== 16'h0001 || fd_c !== 1'b1 || stb_c !== 16'h8000) begin
            n_fail++;
            $display("FAIL clear_final: out=%h/%h fd=%b stb=%h, required 0001 fd=1 stb=8000", out_a, out_c, fd_c, stb_c);
        end else $display("clear_final: out=%h", out_c);
`ifdef DEMUX_PARITY_EN
        n_checks++;
        if (par_c !== 1'b1 || par_a !== 1'b1) begin
            n_fail++;
            $display("FAIL frame_par: par=%b/%b, required 1", par_a, par_c);
        end
`endif
    endtask

    task automatic test_back_to_back();
        // Frame ends, then an immediate beat must be an IDLE request (addressed, mode=0).
        test_scan("b2b_frame", 16'h1234, 16'h0000, 99);
        step(1'b1, 1'b1, 4'd6, 1'b0, 1'b0);
        e = sb.pop_front();
        n_checks++;
        if (out_a !== e.out_a || out_a !== 16'h1274 || stb_a !== 16'h0040 || busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_addr: out=%h stb=%h busy=%b, required out=1274 stb=0040 busy=0", out_a, stb_a, busy_a);
        end else $display("b2b_addr: out=%h stb=%h", out_a, stb_a);
    endtask

    initial begin
        test_reset();
        test_addressed();
        test_fixed_results();
        test_reset_mid_frame();
        test_clear_on_frame();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_1_16_seq.md
DEMUX_1_16_SEQ -- requirements
Module: demux_1_16_seq

Interface
REQ-001 The block SHALL have parameter CLEAR_ON_FRAME, default 0; when 1, all lanes are zeroed on the cycle a scan frame starts.
REQ-002 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port rst, input, 1, an asynchronous active-high reset.
REQ-004 The block SHALL have port din, input, 1, the data bit to be routed.
REQ-005 The block SHALL have port sel, input, 4, the lane address, used in addressed mode only.
REQ-006 The block SHALL have port mode, input, 1: 0 = addressed write, 1 = start scan frame; sampled only in IDLE.
REQ-007 The block SHALL have port in_valid, input, 1, which qualifies din, sel and mode.
REQ-008 The block SHALL have port abort, input, 1, a synchronous scan-frame cancel.
REQ-009 The block SHALL have port out, output, 16, the registered lane values.
REQ-010 The block SHALL have port out_stb, output, 16, a one-hot one-cycle strobe marking the lane written.
REQ-011 The block SHALL have port frame_done, output, 1, a one-cycle pulse when lane 15 of a scan frame is written.
REQ-012 The block SHALL have port busy, output, 1, high while in SCAN.

Function
REQ-013 The state machine SHALL have states IDLE and SCAN, plus a 4-bit lane pointer ptr.
REQ-014 In IDLE, in_valid=1 and mode=0 SHALL give out[sel] <= din and out_stb = one-hot(sel) on the next cycle; the state SHALL stay IDLE.
REQ-015 In IDLE, in_valid=1 and mode=1 SHALL write din to lane 0, set ptr=1 and go to SCAN; if CLEAR_ON_FRAME=1, lanes 1..15 SHALL clear to 0 on the same edge.
REQ-016 In SCAN, each in_valid=1 SHALL write din to out[ptr], strobe lane ptr and increment ptr; sel and mode SHALL be ignored.
REQ-017 In SCAN, the write to lane 15 SHALL assert frame_done for exactly one cycle, coincident with out_stb[15], and SHALL return the block to IDLE with ptr=0 (no wrap into a new frame).
REQ-018 In SCAN, in_valid=0 SHALL hold state, ptr and out; out_stb SHALL be 0.
REQ-019 Latency SHALL be one cycle: out, out_stb and frame_done update on the edge that samples in_valid.
REQ-020 Unwritten lanes SHALL hold their previous values.
REQ-021 abort=1 in SCAN SHALL go to IDLE with ptr=0, with no write and no frame_done, even if in_valid=1 (abort wins); partially written lanes SHALL keep their values.
REQ-022 abort=1 in IDLE SHALL have no effect, and any coincident addressed write SHALL proceed.
REQ-023 out_stb SHALL have at most one bit set; frame_done=1 SHALL imply out_stb[15]=1.
REQ-024 busy SHALL be a registered output equal to (state==SCAN).

Reset
REQ-025 rst=1 SHALL asynchronously force state=IDLE, ptr=0, out=16'h0000, out_stb=0, frame_done=0 and busy=0.
REQ-026 Reset during SCAN SHALL discard the frame; the first post-reset in_valid SHALL be treated as an IDLE request.

Configuration
REQ-027 With DEMUX_PARITY_EN defined, the block SHALL add output frame_par, 1 bit, equal to the XOR of all 16 lanes after the frame's final write; it SHALL be valid and held from the frame_done cycle until the next frame_done, and reset to 0.
REQ-028 Without DEMUX_PARITY_EN, the frame_par port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-029 Package demux_pkg SHALL hold LANES=16, SEL_W=4 and the state enum typedef (IDLE, SCAN).
REQ-030 Sub-module dec_4_16 (combinational 4-to-16 one-hot decoder) SHALL generate the lane-write enables from sel or ptr.

Verification
REQ-031 Reset, then addressed writes of din=1 to sel=3 and sel=12 SHALL give out=16'h1008 and out_stb=16'h0008 then 16'h1000, each one cycle after its write.
REQ-032 A scan frame of 16 valid beats with pattern 16'hA5C3 (LSB first) SHALL give out=16'hA5C3, frame_done on beat 16 only and busy low the next cycle.
REQ-033 A scan frame with in_valid gaps of 3 idle cycles after beats 4 and 9 SHALL give the same result as REQ-032, with out_stb=0 during the gaps.
REQ-034 Abort asserted together with in_valid on beat 8 SHALL leave lanes 0..6 written and lane 7 unchanged, with no frame_done, ptr=0 and busy=0.
REQ-035 Asserting rst mid-frame at beat 5 SHALL immediately give out=0 and busy=0; an addressed write to sel=15 afterwards SHALL give out=16'h8000.
REQ-036 With CLEAR_ON_FRAME=1 and DEMUX_PARITY_EN defined, preloading out=16'hFFFF and then scanning 16'h0001 SHALL clear lanes on the start edge, end with out=16'h0001 and give frame_par=1.
